cic_decimator: RTL and testbench
================================

# cic_decimator

Integer-ratio CIC (cascaded integrator-comb) decimation filter for the rate-change chain. It consumes samples qualified by a high-rate enable and emits one filtered sample per `R` accepted inputs, with a single-cycle output enable. It sits upstream of the zero-stuff/hold rate-change stage on the receive path, where it provides the anti-alias filtering and the slow-side enable that the rate-change stage needs.

## Interface
- `W`, 10: input sample width, signed.
- `R`, 4: decimation ratio, integer ≥ 2.
- `N`, 3: number of integrator and comb stages, 1..6.
- `WO`, 16: output width, signed; must satisfy `WO ≤ WI`, where `WI = W + N*$clog2(R)`.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  input-sample enable; `in` is accepted on any edge where `en` = 1.
- `in`  in  W  signed input sample.
- `out`  out  WO  signed decimated output; held between strobes.
- `out_en`  out  1  one-cycle pulse marking a new `out` value.

## Operation
- Internal width is `WI`. All integrator and comb arithmetic is two's-complement modulo 2^WI. Integrator wrap-around is allowed and required; it is the normal CIC behaviour and must not saturate.
- Integrator stage k (k = 1..N): on `en`, `I_k <= I_k + I_{k-1}`, where `I_0` is `in` sign-extended to WI.
- Phase counter `cnt` counts 0..R-1 and advances only on `en`. When `en` = 1 and `cnt` = R-1, the new `I_N` is marked for decimation and `cnt` wraps to 0.
- Decimation register `D` captures `I_N` on the cycle after the marking edge, and its valid bit is set.
- Comb stage k: `C_k <= C_{k-1} - Cprev_k` and `Cprev_k <= C_{k-1}`. Each stage advances only when its input valid is set. The valid bit shifts down the pipeline one stage per clock.
- Output stage: `out <=` comb result scaled to WO by dropping `WI-WO` LSBs (see Configuration). `out_en` pulses high for one clock.
- DC gain is R^N. A constant input `x` settles to `x*R^N >> (WI-WO)`.
- `en` gaps of any length are tolerated; state freezes except the in-flight comb/output pipeline, which continues to drain.
- `en` may be asserted every clock. Because R ≥ 2, the comb pipeline never receives back-to-back entries.

## Timing
- Reset (`rst_n` = 0 at an edge) clears all integrators, `cnt`, `D`, combs, all valid bits, `out` = 0 and `out_en` = 0. This takes effect immediately, including mid-group and mid-pipeline; in-flight results are discarded.
- Latency: `out_en` is high exactly N+2 clocks after the edge that accepted the R-th `en` of a group.
- The first output after reset reflects the first R accepted inputs. The comb history is zero at reset, so the first N outputs are transient.
- `en` is ignored while `rst_n` = 0.

## Configuration
- Macro: `CIC_DECI_ROUND_EN`.
- Undefined: the output stage truncates, dropping `WI-WO` LSBs (floor).
- Defined, with `WI > WO`:
  - Add 2^(WI-WO-1) before the shift (round half up).
  - Saturate to the WO signed range if the addition overflows.
  - This adds no cycle of latency.
- Defined, with `WI = WO`: identical to truncation.

## Structure
- Package `cic_pkg` holds:
  - the constant function `cic_wi(W, R, N)` returning the internal width;
  - the rounding/saturation function `cic_scale`.
- Sub-module `cic_comb` implements one registered comb stage with valid in/out. It is instantiated N times in a generate loop.
- Integrators, counter, decimation register and output stage stay in the top module.

## Test plan
- Use W=10, R=4, N=3, WO=16 (so WI=16) unless stated otherwise.
- DC: `in`=1 with `en` every clock. After transients, `out`=64 on every `out_en`; `out_en` period is 4 clocks.
- Extreme DC: `in`=-512 with `en` every clock. Output settles to -32768, with no corruption despite integrator wrap.
- Impulse: `in`=1 on the first `en` of a group, 0 afterwards. Successive outputs are 10, 6, 0, 0. Check `out_en` exactly 5 clocks after the 4th `en`.
- Gapped enable: `en` asserted every 3rd clock with `in`=1. `out`=64 is still reached, and the `out_en` period is 12 clocks.
- Mid-operation reset: pulse `rst_n` low one clock after 2 `en`s of a group. Expect `out`=0, `out_en`=0 and the counter restarting. Then repeat the impulse test and get identical results.
- Rounding: WO=12 with the impulse stimulus. Without the macro, outputs are 0 and 0; with `CIC_DECI_ROUND_EN`, outputs are 1 and 0.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared helpers for the CIC decimator: internal-width calculation and output scaling.
package cic_pkg;

  function automatic int cic_wi(input int w, input int r, input int n);
    return w + n * $clog2(r);
  endfunction

  // Drop (wi-wo) LSBs; with round_en, round half up and clamp the positive overflow.
  function automatic logic signed [63:0] cic_scale(input logic signed [63:0] x,
                                                   input int wi, input int wo,
                                                   input logic round_en);
    logic signed [63:0] y;
    logic signed [63:0] max_v;
    int sh;
    sh = wi - wo;
    if (sh <= 0) return x;
    if (round_en) begin
      y     = (x + (64'sd1 <<< (sh - 1))) >>> sh;
      max_v = (64'sd1 <<< (wo - 1)) - 64'sd1;
      if (y > max_v) y = max_v;
    end else begin
      y = x >>> sh;
    end
    return y;
  endfunction

endpackage

// File: rtl/cic_comb.sv
// One registered CIC comb stage: y = x - x_prev, advancing only on valid input.
module cic_comb
  import cic_pkg::*;
#(
  parameter int WI = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic signed [WI-1:0] data_i,
  output logic                 valid_o,
  output logic signed [WI-1:0] data_o
);

  logic signed [WI-1:0] prev_q;
  logic signed [WI-1:0] data_q;
  logic                 valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i - prev_q;
        prev_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cic_decimator.sv
// Integer-ratio CIC decimator: N integrators, decimate by R, N comb stages, scaled output.
// Optional macro CIC_DECI_ROUND_EN selects round-half-up with saturation instead of truncation.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int W  = 10,
  parameter int R  = 4,
  parameter int N  = 3,
  parameter int WO = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic signed [W-1:0] in,
  output logic signed [WO-1:0] out,
  output logic                out_en
);

  localparam int WI = cic_wi(W, R, N);
  localparam int CW = $clog2(R);
`ifdef CIC_DECI_ROUND_EN
  localparam logic ROUND = 1'b1;
`else
  localparam logic ROUND = 1'b0;
`endif

  logic signed [WI-1:0] in_ext;
  assign in_ext = WI'(in);

  // Integrators chain combinationally so each sample reaches I_N on the edge that accepts it.
  for (genvar gi = 0; gi < N; gi++) begin : g_int
    logic signed [WI-1:0] acc_q;
    logic signed [WI-1:0] acc_d;
    if (gi == 0) begin : g_first
      assign acc_d = acc_q + in_ext;
    end else begin : g_next
      assign acc_d = acc_q + g_int[gi-1].acc_d;
    end
    always_ff @(posedge clk) begin
      if (!rst_n)  acc_q <= '0;
      else if (en) acc_q <= acc_d;
    end
  end

  logic [CW-1:0]        cnt_q;
  logic                 mark_q;
  logic signed [WI-1:0] dec_q;
  logic                 dec_vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      mark_q    <= 1'b0;
      dec_q     <= '0;
      dec_vld_q <= 1'b0;
    end else begin
      mark_q    <= en && (cnt_q == CW'(R - 1));
      dec_vld_q <= mark_q;
      if (en) cnt_q <= (cnt_q == CW'(R - 1)) ? '0 : cnt_q + 1'b1;
      if (mark_q) dec_q <= g_int[N-1].acc_q;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_comb
    logic signed [WI-1:0] d_in;
    logic signed [WI-1:0] d_out;
    logic                 v_in;
    logic                 v_out;
    if (gi == 0) begin : g_first
      assign d_in = dec_q;
      assign v_in = dec_vld_q;
    end else begin : g_next
      assign d_in = g_comb[gi-1].d_out;
      assign v_in = g_comb[gi-1].v_out;
    end
    cic_comb #(.WI(WI)) u_comb (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (v_in),
      .data_i  (d_in),
      .valid_o (v_out),
      .data_o  (d_out)
    );
  end

  logic signed [WO-1:0] out_q;
  logic                 out_en_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= '0;
      out_en_q <= 1'b0;
    end else begin
      out_en_q <= g_comb[N-1].v_out;
      if (g_comb[N-1].v_out)
        out_q <= WO'(cic_scale(64'(g_comb[N-1].d_out), WI, WO, ROUND));
    end
  end

  assign out    = out_q;
  assign out_en = out_en_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench: two decimators (WO=16 and WO=12) against a boxcar-convolution model.
module tb_cic_decimator;

  localparam int W  = 10;
  localparam int R  = 4;
  localparam int N  = 3;
  localparam int WI = W + N * $clog2(R);
  localparam int L  = N * (R - 1) + 1;
`ifdef CIC_DECI_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic signed [W-1:0] in_s = '0;
  logic signed [15:0]  out16;
  logic signed [11:0]  out12;
  logic                out_en16, out_en12;

  always #5 clk = ~clk;

  cic_decimator #(.W(W), .R(R), .N(N), .WO(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in_s), .out(out16), .out_en(out_en16));
  cic_decimator #(.W(W), .R(R), .N(N), .WO(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in_s), .out(out12), .out_en(out_en12));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the filter is the decimated convolution with (1+z^-1+..+z^-(R-1))^N.
  int h[L];
  int hist[$];
  typedef struct { int due; longint y; } pend_t;
  pend_t  pend[$];
  int     m_cnt = 0;
  int     cyc = 0;
  bit     exp_en = 1'b0;
  longint exp_y = 0;
  bit     chk_on = 1'b0;

  function automatic longint wrap_wi(input longint v);
    longint m;
    m = v & ((longint'(1) << WI) - 1);
    if (m >= (longint'(1) << (WI - 1))) m -= (longint'(1) << WI);
    return m;
  endfunction

  function automatic longint filt();
    longint acc = 0;
    for (int j = 0; j < L && j < hist.size(); j++)
      acc += longint'(h[j]) * longint'(hist[hist.size() - 1 - j]);
    return wrap_wi(acc);
  endfunction

  function automatic longint floor_div(input longint a, input longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint scale(input longint y, input int wo);
    longint d, q, mx;
    if (WI <= wo) return y;
    d  = longint'(1) << (WI - wo);
    mx = (longint'(1) << (wo - 1)) - 1;
    if (!ROUND) return floor_div(y, d);
    q = floor_div(y + d / 2, d);
    return (q > mx) ? mx : q;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      hist.delete();
      pend.delete();
      m_cnt  = 0;
      exp_en = 1'b0;
      exp_y  = 0;
    end else begin
      exp_en = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        exp_en = 1'b1;
        exp_y  = pend[0].y;
        void'(pend.pop_front());
      end
      if (en) begin
        hist.push_back(int'(in_s));
        if (hist.size() > L) void'(hist.pop_front());
        m_cnt++;
        if (m_cnt == R) begin
          m_cnt = 0;
          pend.push_back('{cyc + N + 2, filt()});
        end
      end
    end
  end

  // Per-cycle compare plus capture of strobed outputs for the literal checks.
  longint cap16[$];
  longint cap12[$];
  int     capc[$];

  always @(negedge clk) begin
    if (chk_on) begin
      check("out_en16", longint'(out_en16), longint'(exp_en));
      check("out_en12", longint'(out_en12), longint'(exp_en));
      check("out16", longint'(out16), scale(exp_y, 16));
      check("out12", longint'(out12), scale(exp_y, 12));
    end
    if (out_en16) begin
      cap16.push_back(longint'(out16));
      cap12.push_back(longint'(out12));
      capc.push_back(cyc);
    end
  end

  task automatic step(input logic e, input int v);
    @(negedge clk);
    en   = e;
    in_s = W'(v);
  endtask

  task automatic clear_caps();
    cap16.delete();
    cap12.delete();
    capc.delete();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic impulse(input string tag);
    int acc_cyc;
    acc_cyc = 0;
    clear_caps();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i == 0) ? 1 : 0);
      if (i == 3) acc_cyc = cyc + 1;
    end
    for (int i = 0; i < 12; i++) step(1'b0, 0);
    check({tag, "_count"}, cap16.size(), 4);
    if (cap16.size() >= 4) begin
      check({tag, "_y0"}, cap16[0], 10);
      check({tag, "_y1"}, cap16[1], 6);
      check({tag, "_y2"}, cap16[2], 0);
      check({tag, "_y3"}, cap16[3], 0);
      check({tag, "_latency"}, capc[0] - acc_cyc, N + 2);
      check({tag, "_wo12_y0"}, cap12[0], ROUND ? 1 : 0);
      check({tag, "_wo12_y1"}, cap12[1], 0);
    end
  endtask

  task automatic dc_run(input string tag, input int v, input int groups, input int gap,
                        input longint exp16, input longint exp12, input int period);
    clear_caps();
    for (int i = 0; i < groups * R; i++) begin
      step(1'b1, v);
      for (int g = 1; g < gap; g++) step(1'b0, 0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 0);
    check({tag, "_count"}, cap16.size(), groups);
    if (cap16.size() >= 2) begin
      check({tag, "_out16"}, cap16[cap16.size() - 1], exp16);
      check({tag, "_out12"}, cap12[cap12.size() - 1], exp12);
      check({tag, "_period"}, capc[capc.size() - 1] - capc[capc.size() - 2], period);
    end
  endtask

  initial begin
    int tmp[L];
    for (int i = 0; i < L; i++) h[i] = (i == 0) ? 1 : 0;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < L; i++) begin
        tmp[i] = 0;
        for (int t = 0; t < R; t++) if (i - t >= 0) tmp[i] += h[i - t];
      end
      for (int i = 0; i < L; i++) h[i] = tmp[i];
    end
    // Pin the model itself: (1+z+z^2+z^3)^3 peaks at 12 in the middle.
    check("model_h0", h[0], 1);
    check("model_h4", h[4], 12);
    check("model_h9", h[9], 1);

    do_reset(3);
    chk_on = 1'b1;
    check("reset_out16", longint'(out16), 0);
    check("reset_out_en16", longint'(out_en16), 0);

    impulse("impulse");
    dc_run("dc1", 1, 16, 1, 64, ROUND ? 4 : 4, 4);
    dc_run("dc_min", -512, 16, 1, -32768, -2048, 4);
    dc_run("gapped", 1, 12, 3, 64, 4, 12);

    // Mid-operation reset with a result still in flight.
    do_reset(2);
    for (int i = 0; i < 6; i++) step(1'b1, 100);
    clear_caps();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    check("midrst_out16", longint'(out16), 0);
    check("midrst_out_en16", longint'(out_en16), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 0);
    check("midrst_discard", cap16.size(), 0);
    impulse("impulse2");

    // Random enables, samples and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      en    = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       in_s = 10'sh1FF;
        1:       in_s = 10'sh200;
        default: in_s = W'($urandom_range(0, 1023));
      endcase
    end
    rst_n = 1'b1;
    en    = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
